// File: rtl/micro_seq_pkg.sv
// Shared types for the microprogram sequencer: microword layout, op and
// condition encodings, and the NOP word that keeps the datapath idle.
package micro_seq_pkg;

  typedef enum logic [2:0] {
    OP_CONT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_CJMP  = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_LDCNT = 3'd5,
    OP_LOOP  = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    CS_TRUE = 2'd0,
    CS_Z    = 2'd1,
    CS_OVR  = 2'd2,
    CS_C    = 2'd3
  } csel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Field order fixes the bit positions: fwe[31] br[30:23] cpol[22]
  // csel[21:20] op[19:17] b[16:13] a[12:9] i[8:0].
  typedef struct packed {
    logic       fwe;
    logic [7:0] br;
    logic       cpol;
    csel_e      csel;
    op_e        op;
    logic [3:0] b;
    logic [3:0] a;
    logic [8:0] i;
  } uword_t;

  localparam logic [8:0] NOP_I    = 9'h047;
  localparam uword_t     NOP_WORD = uword_t'(32'h0000_0047);

  // status is {Z, OVR, C}
  function automatic logic cond_hit(input csel_e csel, input logic cpol,
                                    input logic [2:0] status);
    logic c;
    case (csel)
      CS_TRUE: c = 1'b1;
      CS_Z:    c = status[2];
      CS_OVR:  c = status[1];
      default: c = status[0];
    endcase
    return c ^ cpol;
  endfunction

endpackage

// File: rtl/micro_stack.sv
// Return-address LIFO. Overflowing pushes and underflowing pops are dropped
// and reported on err_o in the same cycle.
module micro_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         err_o
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  sp_q;
  logic [W-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign wr_idx  = IDX_W'(sp_q);
  assign top_idx = IDX_W'(sp_q - SP_W'(1));
  assign top_o   = empty_o ? '0 : mem_q[top_idx];
  assign err_o   = (push_i & full_o) | (pop_i & empty_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (clear_i) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
      sp_q          <= sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer feeding an Am2901-style controller: pipelined
// microword register, branch/call/return/loop sequencing and flag capture.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int STACK_D = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              z,
  input  logic              ovr,
  input  logic              g_lo,
  output logic [8:0]        i,
  output logic [3:0]        a,
  output logic [3:0]        b,
  output logic              running,
  output logic              done,
  output logic              stack_err
);

  state_e            state_q, state_d;
  uword_t            pipe_q, pipe_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        status_q, status_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W-1:0] br_addr;
  logic              cond;
  logic              push, pop, clear;
  logic              push_en, pop_en;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty, stk_err;
  uword_t            rom_word;

  assign rom_word = uword_t'(rom_data);
  assign br_addr  = ADDR_W'(pipe_q.br);
  assign cond     = cond_hit(pipe_q.csel, pipe_q.cpol, status_q);
  // Nothing moves on the stack while stalled; the word retries after hold.
  assign push_en  = push & ~hold;
  assign pop_en   = pop & ~hold;

  micro_stack #(
    .DEPTH (STACK_D),
    .W     (ADDR_W)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .push_i  (push_en),
    .pop_i   (pop_en),
    .data_i  (upc_q),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .err_o   (stk_err)
  );

  always_comb begin
    nxt      = upc_q;
    push     = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    state_d  = state_q;
    pipe_d   = pipe_q;
    upc_d    = upc_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    done_d   = done_q;
    err_d    = err_q;

    if (state_q == ST_IDLE) begin
      nxt = '0;
      if (start && !hold) begin
        pipe_d  = rom_word;
        upc_d   = ADDR_W'(1);
        done_d  = 1'b0;
        err_d   = 1'b0;
        clear   = 1'b1;
        state_d = ST_RUN;
      end
    end else begin
      case (pipe_q.op)
        OP_CONT:  nxt = upc_q;
        OP_JMP:   nxt = br_addr;
        OP_CJMP:  nxt = cond ? br_addr : upc_q;
        OP_CALL: begin
          if (cond) begin
            nxt  = br_addr;
            push = 1'b1;
          end
        end
        OP_RET: begin
          if (cond) begin
            pop = 1'b1;
            nxt = stk_empty ? '0 : stk_top;
          end
        end
        OP_LDCNT: cnt_d = pipe_q.br;
        OP_LOOP: begin
          if (cnt_q != 8'd0) begin
            nxt   = br_addr;
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: nxt = upc_q;
      endcase

      pipe_d = rom_word;
      upc_d  = nxt + ADDR_W'(1);
      err_d  = err_q | stk_err;
      if (pipe_q.fwe) status_d = {z, ovr, ~g_lo};
      if (pipe_q.op == OP_HALT) begin
        pipe_d  = NOP_WORD;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pipe_q   <= NOP_WORD;
      upc_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (!hold) begin
      state_q  <= state_d;
      pipe_q   <= pipe_d;
      upc_q    <= upc_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rom_addr  = nxt;
  assign i         = hold ? NOP_I : pipe_q.i;
  assign a         = pipe_q.a;
  assign b         = pipe_q.b;
  assign running   = (state_q == ST_RUN);
  assign done      = done_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: a behavioural ROM whose words
// carry their own address in i/a/b, and a scoreboard of expected issues.
module tb_micro_sequencer;
  import micro_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        hold;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        z, ovr, g_lo;
  logic [8:0]  i_w;
  logic [3:0]  a_w, b_w;
  logic        running, done, stack_err;

  logic [31:0] rom [0:255];
  logic [8:0]  exp_q[$];
  logic [8:0]  obs_q[$];
  logic [7:0]  obs_addr_q[$];
  logic        obs_err_q[$];
  int          checks;
  int          errors;

  assign rom_data = rom[rom_addr];

  micro_sequencer #(.ADDR_W(8), .STACK_D(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .hold      (hold),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .z         (z),
    .ovr       (ovr),
    .g_lo      (g_lo),
    .i         (i_w),
    .a         (a_w),
    .b         (b_w),
    .running   (running),
    .done      (done),
    .stack_err (stack_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each word's i field is {1, addr}, a = addr[3:0], b = ~addr[3:0].
  function automatic logic [31:0] mk(input logic [2:0] op, input logic [7:0] addr,
                                     input logic [7:0] br, input logic [1:0] csel,
                                     input logic cpol, input logic fwe);
    return {fwe, br, cpol, csel, op, ~addr[3:0], addr[3:0], 1'b1, addr};
  endfunction

  function automatic logic [8:0] wid(input logic [7:0] addr);
    return {1'b1, addr};
  endfunction

  // driver tasks
  task automatic fill_halt();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] ad;
      ad = k[7:0];
      rom[k] = mk(OP_HALT, ad, 8'd0, 2'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic put(input logic [7:0] addr, input logic [2:0] op, input logic [7:0] br);
    rom[addr] = mk(op, addr, br, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic pulse_start();
    obs_q.delete();
    obs_addr_q.delete();
    obs_err_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Record one issued word per negedge until the sequencer leaves RUN.
  task automatic collect(input int max_cycles, output logic timed_out);
    for (int c = 0; c < max_cycles; c++) begin
      if (!running) break;
      obs_q.push_back(i_w);
      obs_addr_q.push_back(rom_addr);
      obs_err_q.push_back(stack_err);
      @(negedge clk);
    end
    timed_out = running;
  endtask

  task automatic test_reset();
    checks++;
    if (i_w !== 9'h047 || a_w !== 4'd0 || b_w !== 4'd0) begin
      errors++;
      $display("FAIL reset_iab: got i=%h a=%h b=%h want i=047 a=0 b=0", i_w, a_w, b_w);
    end
    checks++;
    if (rom_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_rom_addr: got %h want 00", rom_addr);
    end
    checks++;
    if ({running, done, stack_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got run/done/err=%b want 000", {running, done, stack_err});
    end
  endtask

  task automatic test_sequential();
    logic to;
    fill_halt();
    for (int k = 0; k < 4; k++) put(8'(k), OP_CONT, 8'd0);
    for (int k = 0; k < 5; k++) exp_q.push_back(wid(8'(k)));
    pulse_start();
    collect(50, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL seq_timeout: still running"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL seq_count: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [8:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL seq_word: got i=%h want %h", o, e); end
    end
    exp_q.delete();
    checks++;
    if ({done, running} !== 2'b10 || i_w !== 9'h047 || rom_addr !== 8'd0) begin
      errors++;
      $display("FAIL seq_halt: got done=%b run=%b i=%h addr=%h want 1 0 047 00",
               done, running, i_w, rom_addr);
    end
  endtask

  task automatic test_loop();
    logic to;
    logic [7:0] seq [8];
    seq = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3};
    fill_halt();
    put(8'd0, OP_LDCNT, 8'd2);
    put(8'd1, OP_CONT, 8'd0);
    put(8'd2, OP_LOOP, 8'd1);
    for (int k = 0; k < 8; k++) exp_q.push_back(wid(seq[k]));
    pulse_start();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL loop_done_clear: got %b want 0", done); end
    collect(50, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL loop_timeout: still running"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL loop_count: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [8:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL loop_word: got i=%h want %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_condition();
    // csel, cpol, z, ovr, g_lo, taken
    logic [6:0] tbl [7];
    tbl = '{7'b01_0_100_1, 7'b01_1_100_0, 7'b01_0_000_0, 7'b10_0_010_1,
            7'b11_0_000_1, 7'b11_0_001_0, 7'b00_0_001_1};
    for (int t = 0; t < 7; t++) begin
      logic to;
      logic [7:0] tgt;
      logic [6:0] row;
      row = tbl[t];
      tgt = row[0] ? 8'h40 : 8'h02;
      fill_halt();
      rom[0] = mk(OP_CONT, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1);
      rom[1] = mk(OP_CJMP, 8'd1, 8'h40, row[6:5], row[4], 1'b0);
      z = row[3]; ovr = row[2]; g_lo = row[1];
      exp_q.push_back(wid(8'd1));
      exp_q.push_back(wid(tgt));
      pulse_start();
      @(negedge clk);
      checks++;
      if (rom_addr !== tgt) begin
        errors++;
        $display("FAIL cond_target row %0d: got addr=%h want %h", t, rom_addr, tgt);
      end
      checks++;
      if (a_w !== 4'h1 || b_w !== 4'he) begin
        errors++;
        $display("FAIL cond_ab row %0d: got a=%h b=%h want 1 e", t, a_w, b_w);
      end
      collect(20, to);
      checks++;
      if (to !== 1'b0 || obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL cond_count row %0d: got %0d words timeout=%b want %0d",
                 t, obs_q.size(), to, exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        logic [8:0] e, o;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL cond_word row %0d: got i=%h want %h", t, o, e); end
      end
      exp_q.delete();
    end
    z = 1'b0; ovr = 1'b0; g_lo = 1'b1;
  endtask

  task automatic test_stack();
    logic to;
    logic [7:0] seq [14];
    // cnt is 0 on entry, so word 0 falls through the first time only.
    seq = '{8'd0, 8'd1, 8'd2, 8'd10, 8'd20, 8'd30, 8'd40,
            8'd50, 8'd31, 8'd21, 8'd11, 8'd3, 8'd0, 8'd60};
    fill_halt();
    put(8'd0, OP_LOOP, 8'd60);
    put(8'd1, OP_LDCNT, 8'd1);
    put(8'd2, OP_CALL, 8'd10);
    put(8'd10, OP_CALL, 8'd20);
    put(8'd20, OP_CALL, 8'd30);
    put(8'd30, OP_CALL, 8'd40);
    put(8'd40, OP_CALL, 8'd50);
    put(8'd50, OP_RET, 8'd0);
    put(8'd31, OP_RET, 8'd0);
    put(8'd21, OP_RET, 8'd0);
    put(8'd11, OP_RET, 8'd0);
    put(8'd3, OP_RET, 8'd0);
    for (int k = 0; k < 14; k++) exp_q.push_back(wid(seq[k]));
    pulse_start();
    collect(60, to);
    checks++;
    if (to !== 1'b0 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stack_count: got %0d words timeout=%b want %0d", obs_q.size(), to, exp_q.size());
    end
    if (obs_q.size() == 14) begin
      checks++;
      if (obs_addr_q[6] !== 8'd50 || obs_err_q[6] !== 1'b0 || obs_err_q[7] !== 1'b1) begin
        errors++;
        $display("FAIL stack_overflow: got addr=%h err=%b,%b want 32 0,1",
                 obs_addr_q[6], obs_err_q[6], obs_err_q[7]);
      end
      checks++;
      if (obs_addr_q[11] !== 8'd0) begin
        errors++;
        $display("FAIL stack_underflow_target: got %h want 00", obs_addr_q[11]);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [8:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL stack_word: got i=%h want %h", o, e); end
    end
    exp_q.delete();
    checks++;
    if (stack_err !== 1'b1) begin errors++; $display("FAIL stack_err_sticky: got %b want 1", stack_err); end
  endtask

  task automatic test_hold();
    logic to;
    fill_halt();
    for (int k = 0; k < 6; k++) put(8'(k), OP_CONT, 8'd0);
    for (int k = 0; k < 7; k++) exp_q.push_back(wid(8'(k)));
    pulse_start();
    checks++;
    if ({stack_err, done} !== 2'b00) begin
      errors++;
      $display("FAIL hold_start_clear: got err/done=%b want 00", {stack_err, done});
    end
    obs_q.push_back(i_w);
    @(negedge clk);
    obs_q.push_back(i_w);
    @(negedge clk);
    hold = 1'b1;
    for (int h = 0; h < 4; h++) begin
      if (h > 0) @(negedge clk);
      #1;
      checks++;
      if (i_w !== 9'h047 || rom_addr !== 8'd3 || a_w !== 4'd2) begin
        errors++;
        $display("FAIL hold_frozen cycle %0d: got i=%h addr=%h a=%h want 047 03 2", h, i_w, rom_addr, a_w);
      end
    end
    hold = 1'b0;
    #1;
    collect(50, to);
    checks++;
    if (to !== 1'b0 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL hold_count: got %0d words timeout=%b want %0d", obs_q.size(), to, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [8:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL hold_word: got i=%h want %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midrun();
    logic to;
    logic [7:0] seq [6];
    seq = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3};
    fill_halt();
    put(8'd0, OP_LDCNT, 8'd200);
    put(8'd1, OP_CONT, 8'd0);
    put(8'd2, OP_LOOP, 8'd1);
    pulse_start();
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (i_w !== 9'h047 || a_w !== 4'd0 || b_w !== 4'd0 || rom_addr !== 8'd0 ||
        {running, done, stack_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_midrun: got i=%h a=%h b=%h addr=%h flags=%b want 047 0 0 00 000",
               i_w, a_w, b_w, rom_addr, {running, done, stack_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    put(8'd0, OP_LDCNT, 8'd1);
    for (int k = 0; k < 6; k++) exp_q.push_back(wid(seq[k]));
    pulse_start();
    collect(50, to);
    checks++;
    if (to !== 1'b0 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL restart_count: got %0d words timeout=%b want %0d", obs_q.size(), to, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [8:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL restart_word: got i=%h want %h", o, e); end
    end
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    hold   = 1'b0;
    z      = 1'b0;
    ovr    = 1'b0;
    g_lo   = 1'b1;
    fill_halt();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_loop();
    test_condition();
    test_stack();
    test_hold();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
